// File: rtl/alu_mult_seq.sv
// alu_mult_seq: multi-cycle 32x32->64 MULT/MULTU sequencer that borrows the
// shared combinational ALU for every add/subtract.
//   - The EX stage owns the ALU whenever busy is low.
//   - Signed operands are made positive first (ABS_A/ABS_B).
//   - The magnitudes are multiplied with one shift-add step per cycle (RUN).
//   - If the signs differed, the 64-bit product is negated (NEG_LO/NEG_HI).
// Signed operations always pass through NEG_LO/NEG_HI, so their latency is fixed.
module alu_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // The counter is wide enough to hold WIDTH-1; RUN ends on that value.
    localparam int             CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE_COUNT  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABS_A  = 3'd1,
        S_ABS_B  = 3'd2,
        S_RUN    = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] mcand_r;
    logic             neg_flag_r;
    logic             signed_r;
    logic             lo_zero_r;
    logic [CW-1:0]    count_r;
    logic             carry_s;

    // In RUN, the ALU adds hi plus an optional mcand with no carry-out port.
    // An unsigned wrap means the sum came out smaller than hi.
    always_comb begin
        carry_s = 1'b0;
        if (alu_result < hi) begin
            carry_s = 1'b1;
        end else begin
            carry_s = 1'b0;
        end
    end

    // Drive the shared ALU from the current state.
    // When idle or done, the ALU is left at a=0, b=0, ADD.
    always_comb begin
        alu_a       = {WIDTH{1'b0}};
        alu_b       = {WIDTH{1'b0}};
        alu_control = ALU_ADD;
        case (state_r)
            S_ABS_A: begin
                alu_b       = mcand_r;
                alu_control = ALU_SUB;
            end
            S_ABS_B: begin
                alu_b       = lo;
                alu_control = ALU_SUB;
            end
            S_RUN: begin
                alu_a       = hi;
                alu_b       = lo[0] ? mcand_r : {WIDTH{1'b0}};
                alu_control = ALU_ADD;
            end
            S_NEG_LO: begin
                alu_b       = lo;
                alu_control = ALU_SUB;
            end
            S_NEG_HI: begin
                alu_b       = hi;
                alu_control = ALU_SUB;
            end
            default: begin
                alu_a       = {WIDTH{1'b0}};
                alu_b       = {WIDTH{1'b0}};
                alu_control = ALU_ADD;
            end
        endcase
    end

    // Sequencer FSM: accept, absolute value, shift-add, negate, and registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= {WIDTH{1'b0}};
            lo         <= {WIDTH{1'b0}};
            mcand_r    <= {WIDTH{1'b0}};
            neg_flag_r <= 1'b0;
            signed_r   <= 1'b0;
            lo_zero_r  <= 1'b0;
            count_r    <= {CW{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mcand_r    <= op_a;
                        lo         <= op_b;
                        hi         <= {WIDTH{1'b0}};
                        count_r    <= {CW{1'b0}};
                        neg_flag_r <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        signed_r   <= op_signed;
                        busy       <= 1'b1;
                        state_r    <= op_signed ? S_ABS_A : S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_ABS_A: begin
                    mcand_r <= mcand_r[WIDTH-1] ? alu_result : mcand_r;
                    state_r <= S_ABS_B;
                end
                S_ABS_B: begin
                    // 0x80000000 negates to itself and is then read as unsigned 2^31.
                    lo      <= lo[WIDTH-1] ? alu_result : lo;
                    state_r <= S_RUN;
                end
                S_RUN: begin
                    hi      <= {carry_s, alu_result[WIDTH-1:1]};
                    lo      <= {alu_result[0], lo[WIDTH-1:1]};
                    count_r <= count_r + ONE_COUNT;
                    if (count_r == LAST_COUNT) begin
                        if (neg_flag_r || signed_r) begin
                            state_r <= S_NEG_LO;
                        end else begin
                            state_r <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_NEG_LO: begin
                    // Remember whether the low word is zero.
                    // That decides if the borrow reaches the high word.
                    lo_zero_r <= (lo == {WIDTH{1'b0}});
                    if (neg_flag_r) begin
                        lo <= alu_result;
                    end else begin
                        lo <= lo;
                    end
                    state_r <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    if (neg_flag_r) begin
                        hi <= lo_zero_r ? alu_result : ~hi;
                    end else begin
                        hi <= hi;
                    end
                    state_r <= S_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq.
//   - A behavioural ALU is attached to the sequencer's ALU ports.
//   - Products are compared against plain 64-bit signed/unsigned multiplication.
module tb_alu_mult_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;

    int errors = 0;
    int checks = 0;

    alu_mult_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_signed   (op_signed),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    // Combinational ALU: ADD=010, SUB=110; any other code yields junk.
    assign alu_result = (alu_control == 3'b010) ? (alu_a + alu_b) :
                        (alu_control == 3'b110) ? (alu_a - alu_b) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from plain arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end else begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            return ua * ub;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, then follow the run until done (bounded).
    // Returns:
    //   - latency in cycles (-1 if done never came);
    //   - hi/lo as seen in the done cycle;
    //   - busy_bad = count of cycles where busy was wrong.
    // If poke_at > 0, a junk start is pulsed in that cycle of the run.
    // On return, the bench is sitting in the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int poke_at, output int lat, output logic [31:0] rh,
                          output logic [31:0] rl, output int busy_bad);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        op_signed = s;
        tick();
        start     = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        op_signed = 1'($urandom);
        lat       = -1;
        rh        = 32'd0;
        rl        = 32'd0;
        busy_bad  = 0;
        for (int k = 1; k <= 60; k++) begin
            if (done === 1'b1) begin
                lat = k;
                rh  = hi;
                rl  = lo;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (k == poke_at) begin
                start = 1'b1;
                op_a  = $urandom;
                op_b  = $urandom;
            end
            tick();
            if (k == poke_at) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op_a  = 32'h1234_5678;
        op_b  = 32'h9ABC_DEF0;
        op_signed = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h_%h exp 0", hi, lo); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 3'b010) begin
            errors++; $display("FAIL reset_alu got a=%h b=%h c=%b exp 0 0 010", alu_a, alu_b, alu_control);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done); end
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] tb [7] = '{32'd5, 32'hFFFF_FFFF, 32'd5, 32'd1, 32'h8000_0000, 32'd0, 32'hFFFF_FFF9};
        logic        ts [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [63:0] te [7] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFE_0000_0001,
                                64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_8000_0000,
                                64'h4000_0000_0000_0000, 64'h0000_0000_0000_0000,
                                64'hFFFF_FFFF_FFFF_FFCF};
        int          lat;
        int          bb;
        logic [31:0] rh;
        logic [31:0] rl;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], ts[i], 0, lat, rh, rl, bb);
            checks++; if (lat !== (ts[i] ? 37 : 33)) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, ts[i] ? 37 : 33); end
            checks++; if ({rh, rl} !== te[i]) begin errors++; $display("FAIL dir%0d_product got %h_%h exp %h", i, rh, rl, te[i]); end
            checks++; if (bb !== 0) begin errors++; $display("FAIL dir%0d_busy got %0d bad cycles exp 0", i, bb); end
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dir%0d_pulse got done=%b busy=%b exp 0 0", i, done, busy); end
            checks++; if (hi !== te[i][63:32] || lo !== te[i][31:0]) begin errors++; $display("FAIL dir%0d_hold got %h_%h exp %h", i, hi, lo, te[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] edges [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
        int          lat;
        int          bb;
        logic [31:0] rh;
        logic [31:0] rl;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(3, 0) == 0) ? edges[$urandom_range(5, 0)] : $urandom;
            b = ($urandom_range(3, 0) == 0) ? edges[$urandom_range(5, 0)] : $urandom;
            s = 1'($urandom);
            exp = ref_mul(a, b, s);
            run_op(a, b, s, 0, lat, rh, rl, bb);
            checks++; if (lat !== (s ? 37 : 33)) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, s ? 37 : 33); end
            checks++; if ({rh, rl} !== exp) begin errors++; $display("FAIL rnd%0d_product a=%h b=%h s=%b got %h_%h exp %h", i, a, b, s, rh, rl, exp); end
            checks++; if (bb !== 0) begin errors++; $display("FAIL rnd%0d_busy got %0d exp 0", i, bb); end
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int          lat;
        int          bb;
        logic [31:0] rh;
        logic [31:0] rl;
        run_op(32'h0001_2345, 32'h0000_BEEF, 1'b0, 10, lat, rh, rl, bb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL ignored_start_latency got %0d exp 33", lat); end
        checks++; if ({rh, rl} !== ref_mul(32'h0001_2345, 32'h0000_BEEF, 1'b0)) begin
            errors++; $display("FAIL ignored_start_product got %h_%h exp %h", rh, rl, ref_mul(32'h0001_2345, 32'h0000_BEEF, 1'b0));
        end
        checks++; if (bb !== 0) begin errors++; $display("FAIL ignored_start_busy got %0d exp 0", bb); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          bb;
        logic [31:0] rh;
        logic [31:0] rl;
        run_op(32'd11, 32'd13, 1'b0, 0, lat, rh, rl, bb);
        checks++; if (lat !== 33 || {rh, rl} !== 64'd143) begin errors++; $display("FAIL b2b_first got lat=%0d %h_%h exp 33 143", lat, rh, rl); end
        // Issued from within the done cycle.
        run_op(32'hFFFF_FFF0, 32'd16, 1'b1, 0, lat, rh, rl, bb);
        checks++; if (lat !== 37) begin errors++; $display("FAIL b2b_second_latency got %0d exp 37", lat); end
        checks++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FF00) begin errors++; $display("FAIL b2b_second_product got %h_%h exp ffffffffffffff00", rh, rl); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL b2b_busy got %0d exp 0", bb); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int          done_seen;
        int          lat;
        int          bb;
        logic [31:0] rh;
        logic [31:0] rl;
        start     = 1'b1;
        op_a      = 32'hFFFF_FFFF;
        op_b      = 32'hFFFF_FFFF;
        op_signed = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k < 15; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_status got busy=%b done=%b exp 0 0", busy, done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo got %h_%h exp 0", hi, lo); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 3'b010) begin
            errors++; $display("FAIL midreset_alu got a=%h b=%h c=%b exp 0 0 010", alu_a, alu_b, alu_control);
        end
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            tick();
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles exp 0", done_seen); end
        run_op(32'd1000, 32'hFFFF_FC18, 1'b1, 0, lat, rh, rl, bb);
        checks++; if (lat !== 37 || {rh, rl} !== ref_mul(32'd1000, 32'hFFFF_FC18, 1'b1)) begin
            errors++; $display("FAIL midreset_recover got lat=%0d %h_%h exp 37 %h", lat, rh, rl, ref_mul(32'd1000, 32'hFFFF_FC18, 1'b1));
        end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op_signed = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
